shift_frame_sequencer: RTL and testbench



---
 rtl/shift_frame_sequencer_pkg.sv | 24 ++
 rtl/shift_frame_sequencer_core.sv | 54 +++++
 rtl/shift_frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_shift_frame_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_frame_sequencer_pkg.sv
// Shared definitions for the shift frame sequencer: FSM state encoding and
// helpers that derive the beat count and beat-counter width from the word
// and beat widths.
package shift_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Number of serial beats that make up one parallel word.
  function automatic int beat_count(input int pw, input int sw);
    return pw / sw;
  endfunction

  // Width of the beat counter; it must hold 0 .. N-1.
  function automatic int beat_cnt_width(input int pw, input int sw);
    int n;
    n = pw / sw;
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_frame_sequencer_core.sv
// Parallel/serial shift register with load and beat enable, plus the beat
// counter. The register shifts MSB-first: the top beat leaves while the new
// serial beat enters at the bottom.
module shift_frame_core
  import shift_frame_sequencer_pkg::*;
#(
  parameter int PW = 32,
  parameter int SW = 1,
  parameter int CW = 5
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          i_load,
  input  logic [PW-1:0] i_load_data,
  input  logic          i_shift,
  input  logic          i_clear_cnt,
  input  logic [SW-1:0] i_sin,
  output logic [PW-1:0] o_sreg,
  output logic [CW-1:0] o_beat_cnt
);

  logic [PW-1:0] r_sreg;
  logic [CW-1:0] r_beat_cnt;

  // Shift register: clear hold on abort, load a new word, or advance one beat.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sreg <= '0;
    end else if (i_clear_cnt) begin
      r_sreg <= r_sreg;
    end else if (i_load) begin
      r_sreg <= i_load_data;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[PW-SW-1:0], i_sin};
    end
  end

  // Beat counter: zeroed on load and on abort, counts accepted beats.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_beat_cnt <= '0;
    end else if (i_clear_cnt || i_load) begin
      r_beat_cnt <= '0;
    end else if (i_shift) begin
      r_beat_cnt <= r_beat_cnt + CW'(1);
    end
  end

  assign o_sreg     = r_sreg;
  assign o_beat_cnt = r_beat_cnt;

endmodule

// File: rtl/shift_frame_sequencer.sv
// Frame sequencer: accepts a word, shifts it out over N = pwidth/swidth
// strobed beats while capturing SIn, then presents the captured word.
// Optional build macro SHIFT_FRAME_SEQ_FRAMECOUNT_EN adds a 16-bit
// completed-frame counter output FrameCount.
module shift_frame_sequencer
  import shift_frame_sequencer_pkg::*;
#(
  parameter int pwidth = 32,
  parameter int swidth = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [pwidth-1:0] InData,
  input  logic              InValid,
  output logic              InReady,
  input  logic              Strobe,
  input  logic              Abort,
  input  logic [swidth-1:0] SIn,
  output logic [swidth-1:0] SOut,
  output logic              SValid,
  output logic              SFirst,
  output logic              SLast,
  output logic [pwidth-1:0] OutData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy
`ifdef SHIFT_FRAME_SEQ_FRAMECOUNT_EN
  ,
  output logic [15:0]       FrameCount
`endif
);

  localparam int N  = beat_count(pwidth, swidth);
  localparam int CW = beat_cnt_width(pwidth, swidth);
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  if (((pwidth % swidth) != 0) || (N < 2)) begin : g_param_check
    $fatal(1, "shift_frame_sequencer: pwidth must be a multiple of swidth with pwidth/swidth >= 2");
  end

  state_t            r_state;
  state_t            w_next;
  logic              w_load;
  logic              w_shift;
  logic              w_clear;
  logic              w_done_hs;
  logic [pwidth-1:0] w_sreg;
  logic [CW-1:0]     w_beat_cnt;

  shift_frame_core #(
    .PW (pwidth),
    .SW (swidth),
    .CW (CW)
  ) u_core (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_load      (w_load),
    .i_load_data (InData),
    .i_shift     (w_shift),
    .i_clear_cnt (w_clear),
    .i_sin       (SIn),
    .o_sreg      (w_sreg),
    .o_beat_cnt  (w_beat_cnt)
  );

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake decode; Abort overrides every other request.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_clear   = 1'b0;
    w_done_hs = 1'b0;
    InReady   = 1'b0;
    SValid    = 1'b0;
    SFirst    = 1'b0;
    SLast     = 1'b0;
    OutValid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        InReady = ~Abort;
        if (InValid && !Abort) begin
          w_load = 1'b1;
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        SValid = Strobe;
        SFirst = Strobe && (w_beat_cnt == '0);
        SLast  = Strobe && (w_beat_cnt == LAST_BEAT);
        if (Strobe && !Abort) begin
          w_shift = 1'b1;
          if (w_beat_cnt == LAST_BEAT) begin
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        OutValid = 1'b1;
        if (OutReady && !Abort) begin
          w_done_hs = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (Abort) begin
      w_clear = 1'b1;
      w_next  = ST_IDLE;
    end
  end

  // SOut comes straight from register bits so it can be packed into the IO.
  assign SOut    = w_sreg[pwidth-1 -: swidth];
  assign OutData = w_sreg;
  assign Busy    = (r_state != ST_IDLE);

`ifdef SHIFT_FRAME_SEQ_FRAMECOUNT_EN
  logic [15:0] r_frame_cnt;

  // Completed-frame counter; wraps naturally at 16 bits.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_frame_cnt <= '0;
    end else if (w_done_hs) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign FrameCount = r_frame_cnt;
`endif

endmodule

// File: tb/tb_shift_frame_sequencer.sv
// Self-checking bench for shift_frame_sequencer with pwidth=8, swidth=2.
module tb_shift_frame_sequencer;

  localparam int PW = 8;
  localparam int SW = 2;
  localparam int N  = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [PW-1:0] InData = '0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic          Strobe = 1'b0;
  logic          Abort = 1'b0;
  logic [SW-1:0] SIn = '0;
  logic [SW-1:0] SOut;
  logic          SValid;
  logic          SFirst;
  logic          SLast;
  logic [PW-1:0] OutData;
  logic          OutValid;
  logic          OutReady = 1'b1;
  logic          Busy;
`ifdef SHIFT_FRAME_SEQ_FRAMECOUNT_EN
  logic [15:0]   FrameCount;
`endif

  shift_frame_sequencer #(.pwidth(PW), .swidth(SW)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .InData   (InData),
    .InValid  (InValid),
    .InReady  (InReady),
    .Strobe   (Strobe),
    .Abort    (Abort),
    .SIn      (SIn),
    .SOut     (SOut),
    .SValid   (SValid),
    .SFirst   (SFirst),
    .SLast    (SLast),
    .OutData  (OutData),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Busy     (Busy)
`ifdef SHIFT_FRAME_SEQ_FRAMECOUNT_EN
    ,
    .FrameCount (FrameCount)
`endif
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int exp_frames = 0;

  typedef struct packed {
    logic [1:0] sout;
    logic       first;
    logic       last;
  } beat_t;

  beat_t      beat_q[$];
  logic [7:0] word_q[$];

  // Directed vectors with hand-computed serial output and captured word.
  logic [7:0] vec_word [4] = '{8'hB4, 8'h1B, 8'hE7, 8'h5A};
  logic [1:0] vec_sin  [4][4] = '{'{2'd1, 2'd0, 2'd3, 2'd2},
                                  '{2'd3, 2'd3, 2'd0, 2'd1},
                                  '{2'd0, 2'd2, 2'd1, 2'd3},
                                  '{2'd2, 2'd0, 2'd0, 2'd3}};
  logic [1:0] vec_sout [4][4] = '{'{2'd2, 2'd3, 2'd1, 2'd0},
                                  '{2'd0, 2'd1, 2'd2, 2'd3},
                                  '{2'd3, 2'd2, 2'd1, 2'd3},
                                  '{2'd1, 2'd1, 2'd2, 2'd2}};
  logic [7:0] vec_out  [4] = '{8'h4E, 8'hF1, 8'h27, 8'h83};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat or a word.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (SValid) begin
        if (beat_q.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check("sout", 32'(SOut), 32'(b.sout));
          check("sfirst", 32'(SFirst), 32'(b.first));
          check("slast", 32'(SLast), 32'(b.last));
        end
      end
      if (OutValid && word_q.size() == 0) begin
        fail("unexpected_outvalid");
      end else if (OutValid && OutReady) begin
        check("outdata", 32'(OutData), 32'(word_q.pop_front()));
      end
    end
  end

  task automatic send_word(input logic [7:0] w, output int t_acc);
    int  k;
    bit  got;
    k   = 0;
    got = 1'b0;
    InData  = w;
    InValid = 1'b1;
    while (!got && k < 20) begin
      @(negedge Clock);
      if (InReady) got = 1'b1;
      k++;
    end
    if (!got) fail("accept_timeout");
    t_acc = cyc;
    @(posedge Clock); #1;
    InValid = 1'b0;
  endtask

  task automatic shift_beats(input int v, input bit gap, input int nbeats);
    int    beat;
    int    k;
    beat_t b;
    beat = 0;
    k    = 0;
    while (beat < nbeats && k < 64) begin
      Strobe = gap ? ((k % 3) == 0) : 1'b1;
      SIn    = vec_sin[v][beat];
      if (Strobe) begin
        b.sout  = vec_sout[v][beat];
        b.first = (beat == 0);
        b.last  = (beat == N - 1);
        beat_q.push_back(b);
      end
      @(negedge Clock);
      check("busy_in_shift", 32'(Busy), 32'd1);
      if (!Strobe) check("no_svalid_in_gap", 32'(SValid), 32'd0);
      @(posedge Clock); #1;
      if (Strobe) beat++;
      k++;
    end
    Strobe = 1'b0;
    if (beat < nbeats) fail("shift_timeout");
  endtask

  task automatic finish_frame(input int v, input int t_acc, input bit chk_lat);
    int k;
    bit got;
    k   = 0;
    got = 1'b0;
    word_q.push_back(vec_out[v]);
    while (!got && k < 20) begin
      @(negedge Clock);
      if (OutValid) got = 1'b1;
      k++;
    end
    if (!got) begin
      fail("outvalid_timeout");
    end else if (chk_lat) begin
      check("outvalid_latency", 32'(cyc - t_acc), 32'(N + 1));
    end
    @(posedge Clock); #1;
    exp_frames++;
  endtask

  task automatic full_frame(input int v, input bit gap, input bit chk_lat);
    int t;
    send_word(vec_word[v], t);
    shift_beats(v, gap, N);
    finish_frame(v, t, chk_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t;
    // Reset values while Reset is held.
    #2;
    check("rst_inready", 32'(InReady), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_svalid", 32'(SValid), 32'd0);
    check("rst_sfirst_slast", 32'({SFirst, SLast}), 32'd0);
    check("rst_sout", 32'(SOut), 32'd0);
    check("rst_outdata", 32'(OutData), 32'd0);
    repeat (2) @(posedge Clock);
    #3 Reset = 1'b0;
    @(posedge Clock); #1;

    // Basic full-duplex frame with latency check.
    full_frame(0, 1'b0, 1'b1);

    // Strobe gapping with the same vector.
    full_frame(0, 1'b1, 1'b0);

    // Output backpressure: 10 stalled cycles in DONE with a word on offer.
    OutReady = 1'b0;
    send_word(vec_word[2], t);
    shift_beats(2, 1'b0, N);
    word_q.push_back(vec_out[2]);
    InData  = vec_word[3];
    InValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check("stall_outvalid", 32'(OutValid), 32'd1);
      check("stall_outdata", 32'(OutData), 32'(vec_out[2]));
      check("stall_inready", 32'(InReady), 32'd0);
    end
    @(posedge Clock); #1;
    OutReady = 1'b1;
    @(negedge Clock);
    check("handshake_inready", 32'(InReady), 32'd0);
    @(posedge Clock); #1;
    exp_frames++;
    @(negedge Clock);
    check("after_hs_idle", 32'({Busy, InReady}), 32'b01);
    t = cyc;
    @(posedge Clock); #1;
    InValid = 1'b0;
    shift_beats(3, 1'b0, N);
    finish_frame(3, t, 1'b1);

    // Abort mid-frame after two beats.
    send_word(vec_word[1], t);
    shift_beats(1, 1'b0, 2);
    Abort = 1'b1;
    @(posedge Clock); #1;
    Abort = 1'b0;
    @(negedge Clock);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_outvalid", 32'(OutValid), 32'd0);
    check("abort_inready", 32'(InReady), 32'd1);
    check("abort_reg_held", 32'(SOut), 32'd2);
    // Abort coincident with InValid in IDLE.
    @(posedge Clock); #1;
    InData  = vec_word[0];
    InValid = 1'b1;
    Abort   = 1'b1;
    @(negedge Clock);
    check("abort_idle_inready", 32'(InReady), 32'd0);
    @(posedge Clock); #1;
    InValid = 1'b0;
    Abort   = 1'b0;
    @(negedge Clock);
    check("abort_idle_not_taken", 32'(Busy), 32'd0);
    repeat (3) @(posedge Clock);
    #1;
    full_frame(1, 1'b0, 1'b1);

    // Async reset mid-SHIFT, asserted between edges.
    send_word(vec_word[2], t);
    shift_beats(2, 1'b0, 2);
    @(posedge Clock); #3;
    Reset = 1'b1;
    #1;
    check("areset_busy", 32'(Busy), 32'd0);
    check("areset_sout", 32'(SOut), 32'd0);
    check("areset_outdata", 32'(OutData), 32'd0);
    check("areset_inready", 32'(InReady), 32'd1);
    check("areset_outvalid", 32'(OutValid), 32'd0);
    exp_frames = 0;
    @(posedge Clock); #3;
    Reset = 1'b0;
    @(posedge Clock); #1;
    check("post_reset_inready", 32'(InReady), 32'd1);
    full_frame(3, 1'b0, 1'b1);

`ifdef SHIFT_FRAME_SEQ_FRAMECOUNT_EN
    full_frame(0, 1'b0, 1'b0);
    send_word(vec_word[1], t);
    shift_beats(1, 1'b0, 2);
    Abort = 1'b1;
    @(posedge Clock); #1;
    Abort = 1'b0;
    full_frame(2, 1'b0, 1'b0);
    @(negedge Clock);
    check("frame_count", 32'(FrameCount), 32'(exp_frames));
`endif

    repeat (3) @(posedge Clock);
    #1;
    check("beat_q_drained", 32'(beat_q.size()), 32'd0);
    check("word_q_drained", 32'(word_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
